// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams, transmitter handshake and grant status of the UART TX arbiter.
// master = arbiter side, slave = requesters plus uart_tx serializer.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0][7:0] req_data;
    logic [NUM_REQ-1:0]      req_last;
    logic [NUM_REQ-1:0]      req_ready;
    logic [7:0]              tx_data;
    logic                    tx_start;
    logic                    tx_busy;
    logic                    grant_valid;
    logic [IDW-1:0]          grant_id;

    modport master (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_data, tx_start, grant_valid, grant_id
    );

    modport slave (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_data, tx_start, grant_valid, grant_id
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter; one byte in flight, bursts end on last/MAX_BURST.
// Build option UART_ARB_PRIO0_EN: requester 0 becomes strict high priority and preempts at byte boundaries.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IDW       = 2,
    parameter int MAX_BURST = 16
) (
    input logic               clk,
    input logic               rst,
    uart_tx_arbiter_if.master bus
);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

    state_t             state, state_next;
    logic [IDW-1:0]     owner, owner_next;
    logic [IDW-1:0]     ptr, ptr_next;
    logic [IDW-1:0]     winner, cand;
    logic               found;
    logic               granted, granted_next;
    logic [NUM_REQ-1:0] ready, ready_next;
    logic [7:0]         data, data_next;
    logic               start, start_next;
    logic               last, last_next;
    logic [CW-1:0]      count, count_next;
    logic               owner_valid;
    logic               preempt;
    logic               burst_end;

    // Search upward from ptr+1 with wrap, so the last owner gets lowest priority.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
`ifdef UART_ARB_PRIO0_EN
        if (bus.req_valid[0]) begin
            found = 1'b1;
        end
`endif
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NUM_REQ);
            if (!found && bus.req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

`ifdef UART_ARB_PRIO0_EN
    assign preempt = bus.req_valid[0] && (owner != '0);
`else
    assign preempt = 1'b0;
`endif

    assign owner_valid = bus.req_valid[owner];
    assign burst_end   = last || (count == CW'(MAX_BURST)) || preempt;

    always_comb begin
        state_next   = state;
        owner_next   = owner;
        ptr_next     = ptr;
        granted_next = granted;
        ready_next   = ready;
        data_next    = data;
        start_next   = start;
        last_next    = last;
        count_next   = count;

        case (state)
            IDLE: begin
                if (found) begin
                    state_next   = LOAD;
                    granted_next = 1'b1;
                    owner_next   = winner;
                    count_next   = '0;
                    ready_next   = bus.tx_busy ? '0 : (NUM_REQ'(1) << winner);
                end
            end

            LOAD: begin
                if (!owner_valid) begin
                    // Requester gave up mid-packet: nothing was taken, hand the slot on.
                    state_next   = IDLE;
                    granted_next = 1'b0;
                    ready_next   = '0;
                    ptr_next     = owner;
                end else if (ready[owner]) begin
                    state_next = WAIT_BUSY;
                    data_next  = bus.req_data[owner];
                    last_next  = bus.req_last[owner];
                    count_next = count + 1'b1;
                    start_next = 1'b1;
                    ready_next = '0;
                end else begin
                    ready_next = bus.tx_busy ? '0 : (NUM_REQ'(1) << owner);
                end
            end

            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_next = WAIT_DONE;
                    start_next = 1'b0;
                end
            end

            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (burst_end) begin
                        state_next   = IDLE;
                        granted_next = 1'b0;
                        ptr_next     = owner;
                    end else begin
                        state_next = LOAD;
                        ready_next = NUM_REQ'(1) << owner;
                    end
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= '0;
            ptr     <= IDW'(NUM_REQ - 1);
            granted <= 1'b0;
            ready   <= '0;
            data    <= '0;
            start   <= 1'b0;
            last    <= 1'b0;
            count   <= '0;
        end else begin
            state   <= state_next;
            owner   <= owner_next;
            ptr     <= ptr_next;
            granted <= granted_next;
            ready   <= ready_next;
            data    <= data_next;
            start   <= start_next;
            last    <= last_next;
            count   <= count_next;
        end
    end

    assign bus.req_ready   = ready;
    assign bus.tx_data     = data;
    assign bus.tx_start    = start;
    assign bus.grant_valid = granted;
    assign bus.grant_id    = owner;
endmodule
